// File: rtl/seq_adder64_if.sv
// Request/result and adder-slice bundle for seq_adder64.
// The Sub signal exists only when SEQ_ADDER64_SUB_EN is defined.
interface seq_adder64_if;
   logic        Start;
   logic [63:0] A;
   logic [63:0] B;
   logic        CIn;
`ifdef SEQ_ADDER64_SUB_EN
   logic        Sub;
`endif
   logic [31:0] AddIn1;
   logic [31:0] AddIn2;
   logic        AddCI;
   logic        AddEnable;
   logic [31:0] AddOut;
   logic        AddCO;
   logic        Busy;
   logic        Done;
   logic [63:0] Sum;
   logic        COut;
   logic        Ovf;

`ifdef SEQ_ADDER64_SUB_EN
   modport master (
      output Start, A, B, CIn, Sub,
      input  AddIn1, AddIn2, AddCI, AddEnable,
      output AddOut, AddCO,
      input  Busy, Done, Sum, COut, Ovf
   );
   modport slave (
      input  Start, A, B, CIn, Sub,
      output AddIn1, AddIn2, AddCI, AddEnable,
      input  AddOut, AddCO,
      output Busy, Done, Sum, COut, Ovf
   );
`else
   modport master (
      output Start, A, B, CIn,
      input  AddIn1, AddIn2, AddCI, AddEnable,
      output AddOut, AddCO,
      input  Busy, Done, Sum, COut, Ovf
   );
   modport slave (
      input  Start, A, B, CIn,
      output AddIn1, AddIn2, AddCI, AddEnable,
      input  AddOut, AddCO,
      output Busy, Done, Sum, COut, Ovf
   );
`endif
endinterface

// File: rtl/seq_adder64.sv
// Two-cycle 64-bit add sequencer driving an external 32-bit combinational adder.
// Optional subtract support is enabled by defining SEQ_ADDER64_SUB_EN.
module seq_adder64 (
   input logic          CLK,
   input logic          RST_N,
   seq_adder64_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t      state;
   logic [63:0] a_q;
   logic [63:0] beff_q;
   logic        cin0_q;
   logic [31:0] lo_q;
   logic        carry_q;
   logic [63:0] beff_next;
   logic        cin0_next;

`ifdef SEQ_ADDER64_SUB_EN
   // Subtract is A + ~B + 1; the operand is stored already inverted.
   always_comb begin
      beff_next = bus.Sub ? ~bus.B : bus.B;
      cin0_next = bus.Sub ? 1'b1 : bus.CIn;
   end
`else
   always_comb begin
      beff_next = bus.B;
      cin0_next = bus.CIn;
   end
`endif

   always_comb begin
      bus.AddIn1    = '0;
      bus.AddIn2    = '0;
      bus.AddCI     = 1'b0;
      bus.AddEnable = 1'b0;
      case (state)
         LO: begin
            bus.AddEnable = 1'b1;
            bus.AddIn1    = a_q[31:0];
            bus.AddIn2    = beff_q[31:0];
            bus.AddCI     = cin0_q;
         end
         HI: begin
            bus.AddEnable = 1'b1;
            bus.AddIn1    = a_q[63:32];
            bus.AddIn2    = beff_q[63:32];
            bus.AddCI     = carry_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         a_q      <= '0;
         beff_q   <= '0;
         cin0_q   <= 1'b0;
         lo_q     <= '0;
         carry_q  <= 1'b0;
         bus.Busy <= 1'b0;
         bus.Done <= 1'b0;
         bus.Sum  <= '0;
         bus.COut <= 1'b0;
         bus.Ovf  <= 1'b0;
      end else begin
         bus.Done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.Start) begin
                  a_q      <= bus.A;
                  beff_q   <= beff_next;
                  cin0_q   <= cin0_next;
                  bus.Busy <= 1'b1;
                  state    <= LO;
               end
            end
            LO: begin
               lo_q    <= bus.AddOut;
               carry_q <= bus.AddCO;
               state   <= HI;
            end
            HI: begin
               bus.Sum  <= {bus.AddOut, lo_q};
               bus.COut <= bus.AddCO;
               bus.Ovf  <= (a_q[63] == beff_q[63]) && (bus.AddOut[31] != a_q[63]);
               bus.Done <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               bus.Busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
